text_select_overlay: RTL
========================

Name: text_select_overlay

Overview:
- Upstream/downstream wrapper stage for the 42x38 "SELECT" text glyph ROM (6-bit PixelX/PixelY in, 6-bit colour code out).
- Takes raster coordinates from the VGA controller, generates ROM pixel addresses for an on-screen text box, consumes the ROM colour code, and emits a registered pixel plus valid flag to the frame compositor.
- Owns the menu visibility/blink state machine, updated once per frame so the text never tears mid-frame.

Parameters:
- TEXT_X, 299, left screen column of text box
- TEXT_Y, 200, top screen row of text box
- TEXT_W, 42, glyph width in ROM pixels
- TEXT_H, 38, glyph height in ROM pixels
- BLINK_FRAMES, 30, frames per blink half-period (1..63)
- TRANSPARENT_CODE, 6'h00, ROM colour code treated as transparent

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  synchronous active-low reset
- DrawX  in  10  current raster column
- DrawY  in  10  current raster row
- FrameStart  in  1  one-cycle pulse at start of vertical blank
- Show  in  1  menu requests text visible
- Selected  in  1  menu item highlighted (blink)
- RomPixelX  out  6  ROM column address
- RomPixelY  out  6  ROM row address
- RomData  in  6  ROM colour code (combinational from RomPixelX/Y)
- PixelValid  out  1  overlay pixel opaque and visible
- PixelData  out  6  overlay colour code

Behaviour:
- Reset (Reset_n=0 at clock edge): state=HIDDEN, blink counter=0, RomPixelX/Y=0, in-box pipe flag=0, PixelValid=0, PixelData=0. Reset mid-frame takes effect next edge; no partial pixel emitted.
- Stage 1 (registered): inBox = DrawX in [TEXT_X, TEXT_X+TEXT_W) and DrawY in [TEXT_Y, TEXT_Y+TEXT_H). If inBox: RomPixelX=(DrawX-TEXT_X)[5:0], RomPixelY=(DrawY-TEXT_Y)[5:0]; else both 0. inBox registered alongside.
- Stage 2 (registered): PixelValid = inBox_q & visible & (RomData != TRANSPARENT_CODE); PixelData = PixelValid ? RomData : 0.
- Latency: DrawX/DrawY to PixelValid/PixelData = exactly 2 clocks, fully pipelined, one pixel per clock.
- Box edges inclusive left/top, exclusive right/bottom; DrawX=TEXT_X+TEXT_W-1 maps to RomPixelX=41.
- FSM states HIDDEN, STEADY, BLINK_ON, BLINK_OFF; transitions only on FrameStart cycles, otherwise state holds.
- At FrameStart: Show=0 -> HIDDEN (from any state, counter=0).
- Show=1, Selected=0 -> STEADY (counter=0).
- Show=1, Selected=1: from HIDDEN/STEADY -> BLINK_ON, counter=0; in BLINK_ON/BLINK_OFF, if counter==BLINK_FRAMES-1 toggle ON<->OFF and counter=0, else counter+1.
- Counter 6 bits, never exceeds BLINK_FRAMES-1.
- visible = (state==STEADY)|(state==BLINK_ON); sampled by stage 2 every cycle.
- Show/Selected changes between FrameStart pulses have no effect until next pulse.

Optional Feature:
- Macro TEXT_OVERLAY_SCALE2_EN.
- Defined: box is 2*TEXT_W x 2*TEXT_H screen pixels; RomPixelX=((DrawX-TEXT_X)>>1)[5:0], RomPixelY likewise. Latency unchanged.
- Undefined: 1:1 mapping as above.

Decomposition:
- Shared package text_overlay_pkg: FSM state enum (HIDDEN, STEADY, BLINK_ON, BLINK_OFF), TRANSPARENT_CODE default, glyph width/height constants shared with the text ROMs.
- One natural sub-module: text_blink_fsm (FSM + frame counter; inputs FrameStart/Show/Selected; output visible).
- Address/pipeline logic stays in top.

Test Plan:
- Reset: Reset_n=0 for 2 clocks mid-raster -> PixelValid=0, PixelData=0, RomPixelX/Y=0, state HIDDEN.
- Address map: Show=1, Selected=0, FrameStart pulse; DrawX=299, DrawY=200 -> next clock RomPixelX=0, RomPixelY=0; DrawX=340, DrawY=237 -> 41/37; DrawX=341 -> inBox=0, PixelValid=0 two clocks later.
- Transparency: state STEADY, RomData=6'h00 in box -> PixelValid=0; RomData=6'h15 -> PixelValid=1, PixelData=6'h15 exactly 2 clocks after DrawX/Y.
- Blink: Show=1, Selected=1, BLINK_FRAMES=3, 7 FrameStart pulses -> visible sequence ON,ON,ON,OFF,OFF,OFF,ON.
- Frame-locked: toggle Show 1->0 mid-frame -> overlay remains visible until next FrameStart, then PixelValid=0 everywhere.
- Scale2 (macro defined): DrawX=301, DrawY=203 -> RomPixelX=1, RomPixelY=1; DrawX=382 -> outside box.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// ============================================================================
//  Module      : text_overlay_pkg
//  Description : Shared types and constants for the text overlay blocks.
//                It holds the glyph ROM geometry, the default transparent
//                colour code and the menu visibility/blink state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package text_overlay_pkg;

  // Geometry of the "SELECT" glyph ROM, shared with the text ROMs.
  localparam int GLYPH_W = 42;
  localparam int GLYPH_H = 38;

  // Default placement and blink rate of the text box.
  localparam int DEF_TEXT_X       = 299;
  localparam int DEF_TEXT_Y       = 200;
  localparam int DEF_BLINK_FRAMES = 30;

  // ROM colour code that is rendered as "no pixel".
  localparam logic [5:0] TRANSPARENT_CODE_DEF = 6'h00;

  // Menu visibility / blink states.
  typedef enum logic [1:0] {
    HIDDEN    = 2'd0,
    STEADY    = 2'd1,
    BLINK_ON  = 2'd2,
    BLINK_OFF = 2'd3
  } blink_state_e;

  // A state shows the text when it is steady or in the lit blink phase.
  function automatic logic state_visible(input blink_state_e s);
    return (s == STEADY) || (s == BLINK_ON);
  endfunction

endpackage

`default_nettype wire

// File: rtl/text_blink_fsm.sv
// ============================================================================
//  Module      : text_blink_fsm
//  Description : Frame-locked menu visibility state machine. State and the
//                blink frame counter change only on FrameStart, so the text
//                can never change appearance part way through a frame.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module text_blink_fsm
  import text_overlay_pkg::*;
#(
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic FrameStart,
  input  logic Show,
  input  logic Selected,
  output logic Visible
);

  // Counter value on which the blink phase flips.
  localparam logic [5:0] LAST_FRAME = 6'(BLINK_FRAMES - 1);

  blink_state_e state_q;
  logic [5:0]   cnt_q;
  logic         visible_q;

  // Frame-rate state update; visible_q tracks the state being entered.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= HIDDEN;
      cnt_q     <= 6'd0;
      visible_q <= 1'b0;
    end else if (FrameStart) begin
      if (!Show) begin
        state_q   <= HIDDEN;
        cnt_q     <= 6'd0;
        visible_q <= 1'b0;
      end else if (!Selected) begin
        state_q   <= STEADY;
        cnt_q     <= 6'd0;
        visible_q <= 1'b1;
      end else begin
        case (state_q)
          BLINK_ON, BLINK_OFF: begin
            if (cnt_q == LAST_FRAME) begin
              state_q   <= (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
              cnt_q     <= 6'd0;
              visible_q <= state_visible((state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON);
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
          default: begin
            // Newly highlighted item starts in the lit phase.
            state_q   <= BLINK_ON;
            cnt_q     <= 6'd0;
            visible_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign Visible = visible_q;

endmodule

`default_nettype wire

// File: rtl/text_select_overlay.sv
// ============================================================================
//  Module      : text_select_overlay
//  Description : Wrapper stage around the 42x38 "SELECT" glyph ROM. Stage 1
//                maps the raster position to ROM addresses, stage 2 turns
//                the returned colour code into a registered pixel + valid.
//                DrawX/DrawY to PixelValid/PixelData latency is 2 clocks.
//                Optional macro TEXT_OVERLAY_SCALE2_EN doubles the box size,
//                each ROM pixel covering 2x2 screen pixels.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module text_select_overlay
  import text_overlay_pkg::*;
#(
  parameter int         TEXT_X           = DEF_TEXT_X,
  parameter int         TEXT_Y           = DEF_TEXT_Y,
  parameter int         TEXT_W           = GLYPH_W,
  parameter int         TEXT_H           = GLYPH_H,
  parameter int         BLINK_FRAMES     = DEF_BLINK_FRAMES,
  parameter logic [5:0] TRANSPARENT_CODE = TRANSPARENT_CODE_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       FrameStart,
  input  logic       Show,
  input  logic       Selected,
  output logic [5:0] RomPixelX,
  output logic [5:0] RomPixelY,
  input  logic [5:0] RomData,
  output logic       PixelValid,
  output logic [5:0] PixelData
);

`ifdef TEXT_OVERLAY_SCALE2_EN
  localparam int SCALE_SHIFT = 1;
`else
  localparam int SCALE_SHIFT = 0;
`endif

  // Box bounds in screen pixels: inclusive low edge, exclusive high edge.
  localparam logic [9:0]  X_LO = 10'(TEXT_X);
  localparam logic [9:0]  Y_LO = 10'(TEXT_Y);
  localparam logic [10:0] X_HI = 11'(TEXT_X + (TEXT_W << SCALE_SHIFT));
  localparam logic [10:0] Y_HI = 11'(TEXT_Y + (TEXT_H << SCALE_SHIFT));

  logic       visible;
  logic       in_box;
  logic [5:0] rom_x_d, rom_x_q;
  logic [5:0] rom_y_d, rom_y_q;
  logic       in_box_q;
  logic       pix_valid_d, pix_valid_q;
  logic [5:0] pix_data_d, pix_data_q;

  text_blink_fsm #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .FrameStart (FrameStart),
    .Show       (Show),
    .Selected   (Selected),
    .Visible    (visible)
  );

  // Stage 1 next-state: box test and box-relative ROM address.
  always_comb begin
    in_box  = (DrawX >= X_LO) && ({1'b0, DrawX} < X_HI) &&
              (DrawY >= Y_LO) && ({1'b0, DrawY} < Y_HI);
    rom_x_d = 6'd0;
    rom_y_d = 6'd0;
    if (in_box) begin
      rom_x_d = 6'((DrawX - X_LO) >> SCALE_SHIFT);
      rom_y_d = 6'((DrawY - Y_LO) >> SCALE_SHIFT);
    end
  end

  // Stage 2 next-state: opaque, visible, in-box pixels only.
  always_comb begin
    pix_valid_d = in_box_q && visible && (RomData != TRANSPARENT_CODE);
    pix_data_d  = pix_valid_d ? RomData : 6'd0;
  end

  // Pipeline registers for both stages.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_x_q     <= 6'd0;
      rom_y_q     <= 6'd0;
      in_box_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 6'd0;
    end else begin
      rom_x_q     <= rom_x_d;
      rom_y_q     <= rom_y_d;
      in_box_q    <= in_box;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign RomPixelX  = rom_x_q;
  assign RomPixelY  = rom_y_q;
  assign PixelValid = pix_valid_q;
  assign PixelData  = pix_data_q;

endmodule

`default_nettype wire
